// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two requesters, the arbiter and the register-file write port.
// The slave modport is the arbiter's view; master is the view of whoever drives the requests.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) ();
    logic              a_valid;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  a_ready, b_ready, wr_en, wr_reg, wr_data, conflict_cnt
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output a_ready, b_ready, wr_en, wr_reg, wr_data, conflict_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU/load path (A) and the
// mult/div unit (B); the write port is registered, so a grant commits one cycle later.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned CNT_W      = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam bit FixedPrio = (FIXED_PRIO != 0);

    logic              last_b_q;
    logic              grant_a;
    logic              grant_b;
    logic              contend;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_reg_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [CNT_W-1:0]  cnt_q;

    // A wins a contention unless round-robin says it went last; readys are gated by reset.
    always_comb begin
        contend = bus.a_valid && bus.b_valid;
        grant_a = rst_n && bus.a_valid && (!bus.b_valid || FixedPrio || last_b_q);
        grant_b = rst_n && bus.b_valid && !(bus.a_valid && (FixedPrio || last_b_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_b_q  <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            if (grant_a) begin
                last_b_q  <= 1'b0;
                wr_en_q   <= (bus.a_reg != '0);
                wr_reg_q  <= bus.a_reg;
                wr_data_q <= bus.a_data;
            end else if (grant_b) begin
                last_b_q  <= 1'b1;
                wr_en_q   <= (bus.b_reg != '0);
                wr_reg_q  <= bus.b_reg;
                wr_data_q <= bus.b_data;
            end else begin
                wr_en_q <= 1'b0;
            end
            if (contend && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.a_ready      = grant_a;
    assign bus.b_ready      = grant_b;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_reg       = wr_reg_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority, 4-bit-counter instance share
// the same stimulus.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic [31:0] rf [32];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) rr_if ();
    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  fp_if ();

    assign rr_if.a_valid = a_valid;
    assign rr_if.a_reg   = a_reg;
    assign rr_if.a_data  = a_data;
    assign rr_if.b_valid = b_valid;
    assign rr_if.b_reg   = b_reg;
    assign rr_if.b_data  = b_data;
    assign fp_if.a_valid = a_valid;
    assign fp_if.a_reg   = a_reg;
    assign fp_if.a_data  = a_data;
    assign fp_if.b_valid = b_valid;
    assign fp_if.b_reg   = b_reg;
    assign fp_if.b_data  = b_data;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(0), .CNT_W(16)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rr_if.slave)
    );

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1), .CNT_W(4)) u_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fp_if.slave)
    );

    // Register file commits on the negedge inside the write cycle.
    always @(negedge clk) begin
        if (rr_if.wr_en) rf[rr_if.wr_reg] <= rr_if.wr_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_wr_en", rr_if.wr_en, 0);
        chk("rst_wr_reg", rr_if.wr_reg, 0);
        chk("rst_wr_data", rr_if.wr_data, 0);
        chk("rst_cnt", rr_if.conflict_cnt, 0);
        chk("rst_a_ready", rr_if.a_ready, 0);
        chk("rst_b_ready", rr_if.b_ready, 0);
        tick();
        chk("idle_wr_en", rr_if.wr_en, 0);

        // Single A write
        a_valid = 1'b1; a_reg = 5'd8; a_data = 32'h0000_1234;
        #1;
        chk("single_a_ready", rr_if.a_ready, 1);
        chk("single_b_ready", rr_if.b_ready, 0);
        tick();
        a_valid = 1'b0;
        #1;
        chk("single_wr_en", rr_if.wr_en, 1);
        chk("single_wr_reg", rr_if.wr_reg, 8);
        chk("single_wr_data", rr_if.wr_data, 32'h1234);
        tick();
        chk("single_wr_en_off", rr_if.wr_en, 0);
        chk("single_wr_reg_hold", rr_if.wr_reg, 8);

        // $zero write accepted but dropped; also leaves last_grant = B
        b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFF_FFFF;
        #1;
        chk("zero_b_ready", rr_if.b_ready, 1);
        tick();
        b_valid = 1'b0;
        #1;
        chk("zero_wr_en", rr_if.wr_en, 0);

        // Round-robin contention: A,B,A,B
        a_valid = 1'b1; a_reg = 5'd9;  a_data = 32'hAAAA;
        b_valid = 1'b1; b_reg = 5'd16; b_data = 32'hBBBB;
        #1;
        chk("rr0_a_ready", rr_if.a_ready, 1);
        chk("rr0_b_ready", rr_if.b_ready, 0);
        chk("fp0_b_ready", fp_if.b_ready, 0);
        tick();
        chk("rr1_wr_reg", rr_if.wr_reg, 9);
        chk("rr1_wr_data", rr_if.wr_data, 32'hAAAA);
        chk("rr1_b_ready", rr_if.b_ready, 1);
        chk("fp1_a_ready", fp_if.a_ready, 1);
        tick();
        chk("rr2_wr_reg", rr_if.wr_reg, 16);
        chk("rr2_wr_en", rr_if.wr_en, 1);
        chk("rr2_a_ready", rr_if.a_ready, 1);
        tick();
        chk("rr3_wr_reg", rr_if.wr_reg, 9);
        chk("rr3_b_ready", rr_if.b_ready, 1);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("rr4_wr_reg", rr_if.wr_reg, 16);
        chk("rr4_wr_data", rr_if.wr_data, 32'hBBBB);
        chk("rr_cnt", rr_if.conflict_cnt, 4);
        chk("fp_wr_reg", fp_if.wr_reg, 9);

        // Same-register race: last_grant is B, so A writes first
        a_valid = 1'b1; a_reg = 5'd10; a_data = 32'h1;
        b_valid = 1'b1; b_reg = 5'd10; b_data = 32'h2;
        #1;
        chk("race_a_ready", rr_if.a_ready, 1);
        tick();
        a_valid = 1'b0;
        #1;
        chk("race1_wr_data", rr_if.wr_data, 32'h1);
        chk("race1_b_ready", rr_if.b_ready, 1);
        tick();
        b_valid = 1'b0;
        #1;
        chk("race2_wr_data", rr_if.wr_data, 32'h2);
        chk("race2_wr_en", rr_if.wr_en, 1);
        chk("race_cnt", rr_if.conflict_cnt, 5);
        tick();
        chk("race_rf10", rf[10], 32'h2);

        // Mid-operation reset: A granted, then reset while A is presenting again
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h55;
        tick();
        a_reg = 5'd6; a_data = 32'h66;
        rst_n = 1'b0;
        #1;
        chk("mrst_a_ready", rr_if.a_ready, 0);
        tick();
        a_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("mrst_wr_en", rr_if.wr_en, 0);
        chk("mrst_wr_reg", rr_if.wr_reg, 0);
        chk("mrst_cnt", rr_if.conflict_cnt, 0);
        tick();
        chk("mrst_wr_en2", rr_if.wr_en, 0);

        // last_grant back to B: A wins; then saturation over 20 contended cycles
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h44;
        #1;
        chk("post_rst_a_ready", rr_if.a_ready, 1);
        chk("post_rst_b_ready", rr_if.b_ready, 0);
        for (int i = 0; i < 20; i++) tick();
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("sat_fp_cnt", fp_if.conflict_cnt, 15);
        chk("sat_rr_cnt", rr_if.conflict_cnt, 20);
        tick();
        chk("sat_fp_hold", fp_if.conflict_cnt, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (wrreg/wrdata/write) between two writeback requesters: A is the ALU/load writeback path, B is the multi-cycle mult/div unit.
- Arbitrates with a valid/ready handshake, round-robin by default.
- Drives the write port from registered outputs, so a request is committed exactly one cycle after its grant.
- Drops writes to $zero and keeps a saturating contention counter for performance debug.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register index.
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester A always wins contention.
- CNT_W, 16, width of the contention counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- a_valid  input  1  requester A has a write pending.
- a_reg  input  ADDR_W  destination register index for A.
- a_data  input  DATA_W  write data for A.
- a_ready  output  1  A granted this cycle (combinational).
- b_valid  input  1  requester B has a write pending.
- b_reg  input  ADDR_W  destination register index for B.
- b_data  input  DATA_W  write data for B.
- b_ready  output  1  B granted this cycle (combinational).
- wr_en  output  1  registered write strobe to register file.
- wr_reg  output  ADDR_W  registered write index.
- wr_data  output  DATA_W  registered write data.
- conflict_cnt  output  CNT_W  saturating count of cycles with a_valid and b_valid both high.

Behaviour:
- Reset (rst_n low at posedge):
  - wr_en=0, wr_reg=0, wr_data=0, conflict_cnt=0.
  - last_grant=B, so A wins the first contention.
  - a_ready and b_ready are forced 0 while rst_n is low.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - A requester holds valid, reg and data stable until ready.
  - At most one of a_ready/b_ready is high in any cycle.
  - ready never asserts without the corresponding valid.
- Grant logic (combinational from valid inputs and last_grant):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid, FIXED_PRIO=0: grant the requester that is not last_grant.
  - Both valid, FIXED_PRIO=1: grant A.
  - Neither valid: no grant, last_grant unchanged.
- last_grant updates at posedge to the granted requester whenever a grant occurs, including uncontended grants.
- Output stage (posedge after the grant):
  - wr_reg and wr_data load the granted requester's reg/data.
  - wr_en = 1 if granted reg != 0; otherwise wr_en = 0.
  - A write to $zero is still accepted (ready high) but is silently dropped.
  - Cycle with no grant: wr_en=0; wr_reg and wr_data hold their previous values.
- Latency: a grant in cycle N gives wr_en high in cycle N+1 only. The register file commits it on the negedge inside cycle N+1.
- Back-to-back operation:
  - One write per cycle sustained; no bubbles under continuous requests.
  - With both requesters continuously valid under round-robin, grants alternate A,B,A,B.
  - Neither requester waits more than one cycle.
- Same destination from both requesters in one contention: the winner writes in N+1, the loser in N+2. The loser's value is final.
- conflict_cnt:
  - Increments by 1 on each posedge where a_valid && b_valid and rst_n is high.
  - Saturates at all-ones with no wrap.
- Reset mid-operation:
  - Any grant in the reset cycle is discarded.
  - wr_en is 0 in the following cycle and no pending write survives.
  - Requesters must re-present after reset.

Test Plan:
- Reset then idle: rst_n low 2 cycles, then high with no valids -> wr_en=0, wr_reg=0, wr_data=0, conflict_cnt=0, both readys 0.
- Single A write: a_valid=1, a_reg=8, a_data=0x0000_1234 for one cycle -> a_ready=1 same cycle; next cycle wr_en=1, wr_reg=8, wr_data=0x1234; cycle after, wr_en=0.
- Contention round-robin (FIXED_PRIO=0):
  - Stimulus: A (reg 9, 0xAAAA) and B (reg 16, 0xBBBB) both held valid 4 cycles.
  - Grants: A, B, A, B.
  - wr_reg sequence: 9, 16, 9, 16.
  - conflict_cnt=4.
- Same-register race: A (reg 10, 0x1) and B (reg 10, 0x2) valid together, each dropped after its ready -> wr_data 0x1 then 0x2 on consecutive cycles; final committed value 0x2.
- $zero drop: B valid with b_reg=0, b_data=0xFFFF_FFFF -> b_ready=1; next cycle wr_en=0.
- Mid-operation reset and counter saturation:
  - Reset stimulus: rst_n low during an A grant -> no wr_en in the next cycle; last_grant returns to B, so A wins the next contention.
  - Saturation (CNT_W=4): 20 contended cycles -> conflict_cnt holds 15.
